serial_mag_comp: RTL and testbench
==================================

// Module: serial_mag_comp
// PURPOSE
//   Bit-serial N-bit magnitude comparator built around the 1-bit compare cell.
//   Loads two unsigned operands and presents one bit pair per cycle to the
//   cell, MSB first, on bit_a/bit_b. It folds the cell's LT/EQ/GT answers into
//   one registered N-bit LT/EQ/GT result with a start/done handshake.
//   It is the stage directly upstream (feeds) and downstream (consumes) of the
//   cell.
// PARAMETERS
//   WIDTH       8   operand width in bits; legal range >= 2
//   EARLY_EXIT  1   1: finish at the first unequal bit; 0: always scan all WIDTH bits
// PORTS
//   clk      in   1      single clock; all state updates on rising edge
//   rst      in   1      synchronous reset, active-high
//   start    in   1      request; accepted only in IDLE
//   a_in     in   WIDTH  operand A, unsigned, sampled on accepted start
//   b_in     in   WIDTH  operand B, unsigned, sampled on accepted start
//   bit_a    out  1      current A bit to the cell (MSB of A shift reg)
//   bit_b    out  1      current B bit to the cell (MSB of B shift reg)
//   bit_lt   in   1      cell result for the current bit pair (combinational)
//   bit_eq   in   1      cell result for the current bit pair
//   bit_gt   in   1      cell result for the current bit pair
//   busy     out  1      high while in SHIFT
//   done     out  1      one-cycle pulse; result valid and updated this cycle
//   lt       out  1      A < B, registered, held until next done
//   eq       out  1      A == B, registered, held until next done
//   gt       out  1      A > B, registered, held until next done
//   err      out  1      sticky: cell answer was not one-hot during this compare
// BEHAVIOUR
//   - Reset: state=IDLE; busy, done, lt, eq, gt and err = 0; shift regs and
//     counter = 0. Reset mid-SHIFT aborts the compare with no done pulse.
//   - FSM: IDLE -> SHIFT on start. SHIFT -> FIN on the terminating bit.
//     FIN -> IDLE unconditionally.
//   - IDLE: on start, load a_sh=a_in, b_sh=b_in, cnt=WIDTH-1, first=none,
//     clear err, and go to SHIFT. Without start, hold every output.
//   - start is ignored in SHIFT and FIN; it is neither queued nor an error.
//   - SHIFT, each cycle: bit_a=a_sh[WIDTH-1], bit_b=b_sh[WIDTH-1]. Sample
//     bit_lt, bit_eq and bit_gt in the same cycle. Priority decode:
//     lt > gt > eq, and no bit high counts as eq.
//   - Not one-hot (zero or more than one high): set err (sticky until the next
//     accepted start).
//   - Record first difference: if first==none and the decoded answer is not eq,
//     set first = LT or GT.
//   - Shift a_sh and b_sh left by 1 and decrement cnt.
//   - Terminate when cnt==0, or when EARLY_EXIT=1 and this bit differs.
//   - FIN: done=1 for exactly one cycle. lt/eq/gt = one-hot of first, or eq if
//     first==none. Registered outputs change only in this cycle.
//   - Latency (start accepted in cycle 0): SHIFT starts in cycle 1 and
//     examines bit WIDTH-1-k in cycle 1+k.
//       EARLY_EXIT=0: done in cycle WIDTH+1, always.
//       EARLY_EXIT=1: first differing bit i gives done in cycle WIDTH-i+1.
//       EARLY_EXIT=1, equal operands: done in cycle WIDTH+1.
//   - Throughput: a back-to-back start is accepted in the cycle after FIN at
//     the earliest (FIN -> IDLE, then start).
//   - bit_a/bit_b outside SHIFT: 0.
//   - lt, eq and gt are mutually exclusive at all times; all are 0 until the
//     first done after reset.
// TESTING  (WIDTH=8; cell = the 1-bit comparator unless stubbed)
//   1. a=0x5A, b=0x5A, start @c0 -> busy c1..c8, done @c9, eq=1 lt=0 gt=0, err=0.
//   2. a=0x80, b=0x7F: EARLY_EXIT=1 -> done @c2, gt=1.
//      Same operands, EARLY_EXIT=0 -> done @c9, gt=1.
//   3. a=0x03, b=0x04, EARLY_EXIT=1 -> first diff at bit 2, done @c7, lt=1.
//      Outputs hold until the next done.
//   4. Pulse start @c3 during the compare of test 1 -> ignored, result unchanged.
//      rst @c4 -> busy=0, lt/eq/gt=0, IDLE @c5, no done pulse.
//   5. Stub cell drives bit_lt=bit_gt=1 on the MSB -> err=1, lt=1 (priority).
//      Next start -> err cleared.
//   6. WIDTH=4, both EARLY_EXIT values: all 256 (a,b) pairs vs golden a<b/a==b/a>b.
//      Check done latency and one-hot outputs.

Source files
------------

// File: rtl/serial_mag_comp.sv
// Bit-serial unsigned magnitude comparator: streams operand bit pairs MSB first
// to an external 1-bit compare cell and folds its answers into one LT/EQ/GT result.
module serial_mag_comp #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             bit_a,
  output logic             bit_b,
  input  logic             bit_lt,
  input  logic             bit_eq,
  input  logic             bit_gt,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_FIN   = 2'd2;

  localparam logic [1:0] F_NONE = 2'd0;
  localparam logic [1:0] F_LT   = 2'd1;
  localparam logic [1:0] F_GT   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       first_q, first_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             err_q, err_d;
  logic [1:0]       bit_dec;
  logic [1:0]       first_next;

  function automatic logic one_hot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  // Next-state logic: decode the cell answer (lt beats gt, nothing high means eq)
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    err_d   = err_q;

    if (bit_lt) begin
      bit_dec = F_LT;
    end else if (bit_gt) begin
      bit_dec = F_GT;
    end else begin
      bit_dec = F_NONE;
    end

    if (first_q == F_NONE) begin
      first_next = bit_dec;
    end else begin
      first_next = first_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          cnt_d   = CW'(WIDTH - 1);
          first_d = F_NONE;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        err_d   = err_q | ~one_hot3({bit_lt, bit_eq, bit_gt});
        first_d = first_next;
        a_sh_d  = {a_sh_q[WIDTH-2:0], 1'b0};
        b_sh_d  = {b_sh_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - CW'(1);
        // The result registers are loaded on the edge into FIN, so they update with done.
        if ((cnt_q == CW'(0)) || (EARLY_EXIT && (bit_dec != F_NONE))) begin
          state_d = S_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          lt_d    = (first_next == F_LT);
          gt_d    = (first_next == F_GT);
          eq_d    = (first_next == F_NONE);
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
      first_q <= F_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      err_q   <= err_d;
    end
  end

  assign bit_a = (state_q == S_SHIFT) & a_sh_q[WIDTH-1];
  assign bit_b = (state_q == S_SHIFT) & b_sh_q[WIDTH-1];
  assign busy  = busy_q;
  assign done  = done_q;
  assign lt    = lt_q;
  assign eq    = eq_q;
  assign gt    = gt_q;
  assign err   = err_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Scoreboard bench for serial_mag_comp: four instances (WIDTH 8/4 x EARLY_EXIT 1/0),
// each driving a behavioural 1-bit cell that can be forced into a non-one-hot answer.
module tb_serial_mag_comp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] start_v, stub_v;
  logic [7:0] a_v [4];
  logic [7:0] b_v [4];
  int         stub_cyc [4];
  logic [3:0] bit_a_v, bit_b_v, busy_v, done_v, lt_v, eq_v, gt_v, err_v;

  typedef struct {
    logic lt;
    logic eq;
    logic gt;
    logic err;
    int   cyc;
  } exp_t;

  exp_t sb [4][$];
  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int W  = (g < 2) ? 8 : 4;
    localparam bit EE = ((g % 2) == 0);
    logic cl, ce, cg, stub;
    // Stubbed cell reports lt and gt together on the first SHIFT cycle.
    assign stub = stub_v[g] && (cyc == stub_cyc[g]);
    assign cl = stub | (~bit_a_v[g] & bit_b_v[g]);
    assign ce = ~stub & (bit_a_v[g] == bit_b_v[g]);
    assign cg = stub | (bit_a_v[g] & ~bit_b_v[g]);

    serial_mag_comp #(.WIDTH(W), .EARLY_EXIT(EE)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start_v[g]),
      .a_in   (a_v[g][W-1:0]),
      .b_in   (b_v[g][W-1:0]),
      .bit_a  (bit_a_v[g]),
      .bit_b  (bit_b_v[g]),
      .bit_lt (cl),
      .bit_eq (ce),
      .bit_gt (cg),
      .busy   (busy_v[g]),
      .done   (done_v[g]),
      .lt     (lt_v[g]),
      .eq     (eq_v[g]),
      .gt     (gt_v[g]),
      .err    (err_v[g])
    );
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[dut%0d] @cyc %0d: got %0h expected %0h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic issue(input int d, input logic [7:0] a, input logic [7:0] b,
                       input logic elt, input logic eeq, input logic egt, input logic eerr,
                       input int lat, input bit push);
    exp_t e;
    @(posedge clk); #1;
    a_v[d]      = a;
    b_v[d]      = b;
    start_v[d]  = 1'b1;
    stub_cyc[d] = cyc + 1;
    if (push) begin
      e.lt = elt; e.eq = eeq; e.gt = egt; e.err = eerr; e.cyc = cyc + lat;
      sb[d].push_back(e);
    end
    @(posedge clk); #1;
    start_v[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_v[d]) break;
    end
    if (k == 40) begin
      checks++;
      errors++;
      $display("FAIL done_timeout[dut%0d]: no done within 40 cycles", d);
      sb[d].delete();
    end
  endtask

  // Monitor: pops the scoreboard on every done and checks result exclusivity each cycle
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      if (!rst) begin
        chk("onehot_or_zero", d, 32'(int'(lt_v[d]) + int'(eq_v[d]) + int'(gt_v[d]) <= 1), 32'd1);
      end
      if (done_v[d]) begin
        if (sb[d].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done[dut%0d] @cyc %0d: got done=1 expected none", d, cyc);
        end else begin
          e = sb[d].pop_front();
          chk("lt", d, 32'(lt_v[d]), 32'(e.lt));
          chk("eq", d, 32'(eq_v[d]), 32'(e.eq));
          chk("gt", d, 32'(gt_v[d]), 32'(e.gt));
          chk("err", d, 32'(err_v[d]), 32'(e.err));
          chk("done_cycle", d, cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, hi;
    logic [3:0] x;
    rst     = 1'b1;
    start_v = 4'b0;
    stub_v  = 4'b0;
    for (int d = 0; d < 4; d++) begin
      a_v[d] = 8'h00; b_v[d] = 8'h00; stub_cyc[d] = -1;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("reset_outputs", d, {24'd0, busy_v[d], done_v[d], lt_v[d], eq_v[d], gt_v[d],
                               err_v[d], bit_a_v[d], bit_b_v[d]}, 32'd0);
    end

    // Equal operands, busy window c1..c8, done at c9
    issue(0, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 9, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("busy_window", 0, 32'(busy_v[0]), 32'(k <= 8));
    end
    issue(1, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 9, 1'b1);
    wait_done(1);

    // MSB differs
    issue(0, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1);
    wait_done(0);
    issue(1, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 9, 1'b1);
    wait_done(1);

    // First difference at bit 2, then outputs must hold
    issue(0, 8'h03, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 7, 1'b1);
    wait_done(0);
    issue(1, 8'h03, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 9, 1'b1);
    wait_done(1);
    repeat (5) begin
      @(negedge clk);
      chk("result_hold", 0, {28'd0, done_v[0], lt_v[0], eq_v[0], gt_v[0]}, 32'h4);
    end

    // start pulsed at c3 mid-compare is ignored
    issue(0, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 9, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_v[0] = 8'hFF; b_v[0] = 8'h00; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(0);

    // Reset at c4 aborts the compare with no done pulse
    issue(0, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 9, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_abort", 0, {27'd0, busy_v[0], done_v[0], lt_v[0], eq_v[0], gt_v[0]}, 32'd0);
    repeat (12) @(negedge clk);
    chk("rst_stays_idle", 0, {30'd0, busy_v[0], done_v[0]}, 32'd0);

    // Non-one-hot cell answer on the MSB: lt wins, err set, then cleared by next start
    stub_v[0] = 1'b1;
    issue(0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b1);
    wait_done(0);
    stub_v[0] = 1'b0;
    issue(0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 9, 1'b1);
    @(negedge clk);
    chk("err_cleared", 0, 32'(err_v[0]), 32'd0);
    wait_done(0);
    stub_v[1] = 1'b1;
    issue(1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 9, 1'b1);
    wait_done(1);
    stub_v[1] = 1'b0;

    // WIDTH=4 exhaustive sweep against a golden compare
    for (int d = 2; d < 4; d++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          x  = 4'(a ^ b);
          hi = 0;
          for (int i = 0; i < 4; i++) if (x[i]) hi = i;
          lat = ((a == b) || (d == 3)) ? 5 : (4 - hi + 1);
          issue(d, 8'(a), 8'(b), 1'(a < b), 1'(a == b), 1'(a > b), 1'b0, lat, 1'b1);
          wait_done(d);
        end
      end
    end

    repeat (4) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("scoreboard_drained", d, sb[d].size(), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
